fft_seq_ctrl: RTL and testbench

- Sequencer for the in-place radix-2 DIT FFT datapath.
- Walks stages and butterflies, and issues read addresses for sample pair A/B plus the twiddle ROM address.
- Delays the same pair addresses by the butterfly pipeline latency to produce write-back addresses.
- Inserts drain gaps between stages so no stage reads data still in flight.

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_seq_wb_delay.sv | 35 +++
 rtl/fft_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared state encoding and default geometry for the FFT sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } fft_state_e;

  localparam int unsigned FFT_LOG2N_DEF  = 3;
  localparam int unsigned FFT_BF_LAT_DEF = 3;

endpackage

// File: rtl/fft_seq_wb_delay.sv
// Fixed-length shift register with asynchronous active-low clear; aligns
// read-side pair addresses with the butterfly write-back.
module fft_seq_wb_delay #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned CYCLES = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_q [CYCLES];
  logic [WIDTH-1:0] sr_d [CYCLES];

  always_comb begin
    sr_d[0] = din;
    for (int unsigned i = 1; i < CYCLES; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int unsigned i = 0; i < CYCLES; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[CYCLES-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Radix-2 DIT FFT sequencer: stage/butterfly walk, pair and twiddle addresses,
// delayed write-back addresses. Define FFT_SEQ_HOLD_EN to add the hold input.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N  = FFT_LOG2N_DEF,
  parameter int unsigned BF_LAT = FFT_BF_LAT_DEF
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
`ifdef FFT_SEQ_HOLD_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int unsigned HALF = 1 << (LOG2N - 1);
  localparam int unsigned CW   = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int unsigned DW   = 1 + 2 * LOG2N;

  fft_state_e       state_q, state_d;
  logic [LOG2N-1:0] s_q, s_d;
  logic [LOG2N-2:0] j_q, j_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             arm_q;
  logic             issue_d;
  logic             hold_w;

  logic             busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic [LOG2N-1:0] stage_q, stage_d, a_q, a_d, b_q, b_d;
  logic [LOG2N-2:0] tw_q, tw_d;
  logic [LOG2N-1:0] jx, span, pos, grp, addr_a;
  logic [DW-1:0]    wb_dout;

`ifdef FFT_SEQ_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // arm_q masks start on the first edge after reset release
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
      cnt_q   <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      cnt_q   <= cnt_d;
      arm_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    issue_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && arm_q) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
          issue_d = 1'b1;
        end
      end
      RUN: begin
        if (!hold_w) begin
          if (j_q == (LOG2N-1)'(HALF - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            j_d     = j_q + 1'b1;
            issue_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(BF_LAT - 1)) begin
          if (s_q == LOG2N'(LOG2N - 1)) begin
            state_d = FIN;
          end else begin
            state_d = RUN;
            s_d     = s_q + 1'b1;
            j_d     = '0;
            issue_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        s_d     = '0;
        j_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register in step with it
  always_comb begin
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == FIN);
    rd_en_d = issue_d;
    stage_d = s_d;
    jx      = {1'b0, j_d};
    span    = LOG2N'(1) << s_d;
    pos     = jx & (span - LOG2N'(1));
    grp     = jx >> s_d;
    addr_a  = (grp << (s_d + 1'b1)) | pos;
    a_d     = '0;
    b_d     = '0;
    tw_d    = '0;
    if (issue_d) begin
      a_d  = addr_a;
      b_d  = addr_a + span;
      tw_d = (LOG2N-1)'(pos << (LOG2N - 1 - s_d));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      stage_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      stage_q <= stage_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tw_q    <= tw_d;
    end
  end

  fft_seq_wb_delay #(
    .WIDTH (DW),
    .CYCLES(BF_LAT)
  ) u_wb_delay (
    .clk  (clk),
    .clr_n(clr_n),
    .din  ({rd_en_q, a_q, b_q}),
    .dout (wb_dout)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = a_q;
  assign rd_addr_b = b_q;
  assign tw_addr   = tw_q;
  assign {wr_en, wr_addr_a, wr_addr_b} = wb_dout;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: textbook butterfly enumeration as reference.
`timescale 1ns/1ps
module tb_fft_seq_ctrl;

  localparam int L2       = 3;
  localparam int BL       = 3;
  localparam int N        = 1 << L2;
  localparam int H        = N / 2;
  localparam int BUSY_LEN = L2 * (H + BL);

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic start = 1'b0;
`ifdef FFT_SEQ_HOLD_EN
  logic hold = 1'b0;
`endif
  logic          busy, done, rd_en, wr_en;
  logic [L2-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [L2-2:0] tw_addr;

  fft_seq_ctrl #(.LOG2N(L2), .BF_LAT(BL)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
`ifdef FFT_SEQ_HOLD_EN
    .hold     (hold),
`endif
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
    int st;
  } op_t;

  op_t rdq[$];
  op_t wrq[$];
  int  doneq[$];
  int  busyq[$];

  int cyc = 0;
  int ntests = 0;
  int nfail = 0;
  int tstart = 0;

  op_t me, mw;
  int  pending, bstart, bexp, dexp;
  bit  busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic int all_outs();
    return int'({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
                 wr_en, wr_addr_a, wr_addr_b});
  endfunction

  // Monitor: pops expectations whenever the DUT presents reads, writes, done or a busy window
  always @(negedge clk) begin
    if (!clr_n) begin
      busy_prev = 1'b0;
    end else begin
      if (rd_en) begin
        if (rdq.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          me = rdq.pop_front();
          chk("rd_cyc", cyc, me.cyc);
          chk("rd_a", int'(rd_addr_a), me.a);
          chk("rd_b", int'(rd_addr_b), me.b);
          chk("rd_tw", int'(tw_addr), me.tw);
          chk("rd_stage", int'(stage), me.st);
          pending = 0;
          foreach (wrq[i]) if (wrq[i].st != me.st) pending++;
          chk("rd_hazard", pending, 0);
          me.cyc = me.cyc + BL;
          wrq.push_back(me);
        end
      end
      if (wr_en) begin
        if (wrq.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          mw = wrq.pop_front();
          chk("wr_cyc", cyc, mw.cyc);
          chk("wr_a", int'(wr_addr_a), mw.a);
          chk("wr_b", int'(wr_addr_b), mw.b);
        end
      end
      if (done) begin
        if (doneq.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          dexp = doneq.pop_front();
          chk("done_cyc", cyc, dexp);
          chk("done_busy_low", int'(busy), 0);
        end
      end
      if (busy && !busy_prev) bstart = cyc;
      if (!busy && busy_prev) begin
        if (busyq.size() == 0) begin
          chk("busy_unexpected", 1, 0);
        end else begin
          bexp = busyq.pop_front();
          chk("busy_start", bstart, bexp);
          chk("busy_len", cyc - bstart, BUSY_LEN);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic push_model();
    for (int s = 0; s < L2; s++) begin
      int span;
      int i;
      span = 1 << s;
      i = 0;
      for (int k = 0; k < N; k += 2 * span) begin
        for (int m = 0; m < span; m++) begin
          op_t e;
          e.cyc = tstart + 1 + s * (H + BL) + i;
          e.a   = k + m;
          e.b   = k + m + span;
          e.tw  = m * (N / (2 * span));
          e.st  = s;
          rdq.push_back(e);
          i++;
        end
      end
    end
    doneq.push_back(tstart + BUSY_LEN + 1);
    busyq.push_back(tstart + 1);
  endtask

  task automatic launch();
    @(negedge clk); #1;
    start = 1'b1;
    tstart = cyc;
    push_model();
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_to(input int k);
    while (cyc < tstart + k) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic pulse_stray(input int k);
    wait_to(k);
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  initial begin
    #2;
    chk("reset_outputs", all_outs(), 0);
    // start held over the release edge must be ignored
    @(negedge clk); #1;
    clr_n = 1'b1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    launch();
    pulse_stray(5);
    pulse_stray(22);
    wait_to(22);

    launch();
    wait_to(22);

    launch();
    wait_to(9);
    clr_n = 1'b0;
    #1;
    chk("abort_outputs", all_outs(), 0);
    rdq.delete();
    wrq.delete();
    doneq.delete();
    busyq.delete();
    @(negedge clk);
    @(negedge clk); #1;
    clr_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;

    for (int t = 0; t < 5; t++) begin
      int gap;
      gap = $urandom_range(0, 4);
      repeat (gap) @(negedge clk);
      #1;
      launch();
      if ($urandom_range(0, 1) == 1) pulse_stray($urandom_range(2, 22));
      wait_to(22);
    end

    repeat (8) @(negedge clk);
    #1;
    chk("rdq_drained", rdq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);
    chk("doneq_drained", doneq.size(), 0);
    chk("busyq_drained", busyq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
